ext_bus_arb: RTL

Two-master arbiter that shares the external peripheral bus (the negedge-sampled op/rw/addr/data_w/data_r bus that decodes the GPIO window at 0xf0000000–0xf00000ff) between two requesters, e.g. the core load/store unit and a DMA engine. Each master uses a req/ack handshake. The arbiter grants with round-robin fairness, supports bounded bus locking, registers the selected request onto the bus for exactly one cycle, and returns the read data to the granted master.

---
 rtl/ext_bus_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ext_bus_arb.sv
// Two-master round-robin arbiter for the negedge-sampled external peripheral bus.
// Grants with bounded locking, drives one ACCESS cycle, and returns read data with a one-cycle ack.
module ext_bus_arb #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LOCK_MAX   = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  m0_req,
   input  logic                  m0_rw,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_data_w,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_data_r,
   input  logic                  m1_req,
   input  logic                  m1_rw,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_data_w,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_data_r,
   output logic                  ext_op,
   output logic                  ext_rw,
   output logic [ADDR_WIDTH-1:0] ext_addr,
   output logic [DATA_WIDTH-1:0] ext_data_w,
   input  logic [DATA_WIDTH-1:0] ext_data_r,
   output logic                  owner,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  ext_op_q, ext_op_d;
   logic                  ext_rw_q, ext_rw_d;
   logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
   logic [DATA_WIDTH-1:0] ext_data_w_q, ext_data_w_d;
   logic                  m0_ack_q, m0_ack_d;
   logic                  m1_ack_q, m1_ack_d;
   logic [DATA_WIDTH-1:0] m0_data_r_q, m0_data_r_d;
   logic [DATA_WIDTH-1:0] m1_data_r_q, m1_data_r_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic                  lock_valid_q, lock_valid_d;
   logic                  lock_owner_q, lock_owner_d;
   logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;

   logic lock_hold;
   logic win;
   logic win_lock;

   // Under contention the lock owner keeps the bus until its budget is used up.
   assign lock_hold = lock_valid_q && (lock_cnt_q < CNT_W'(LOCK_MAX));
   assign win       = (m0_req && m1_req) ? (lock_hold ? lock_owner_q : ~last_q) : m1_req;
   assign win_lock  = win ? m1_lock : m0_lock;

   always_comb begin
      state_d      = state_q;
      ext_op_d     = ext_op_q;
      ext_rw_d     = ext_rw_q;
      ext_addr_d   = ext_addr_q;
      ext_data_w_d = ext_data_w_q;
      m0_ack_d     = m0_ack_q;
      m1_ack_d     = m1_ack_q;
      m0_data_r_d  = m0_data_r_q;
      m1_data_r_d  = m1_data_r_q;
      owner_d      = owner_q;
      last_d       = last_q;
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      lock_cnt_d   = lock_cnt_q;

      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               ext_op_d     = 1'b1;
               ext_rw_d     = win ? m1_rw : m0_rw;
               ext_addr_d   = win ? m1_addr : m0_addr;
               ext_data_w_d = win ? m1_data_w : m0_data_w;
               owner_d      = win;
               last_d       = win;
               state_d      = ACCESS;
               if (!win_lock) begin
                  lock_valid_d = 1'b0;
                  lock_cnt_d   = '0;
               end else if (lock_valid_q && (lock_owner_q == win)) begin
                  if (lock_cnt_q < CNT_W'(LOCK_MAX)) begin
                     lock_cnt_d = lock_cnt_q + CNT_W'(1);
                  end
               end else begin
                  lock_valid_d = 1'b1;
                  lock_owner_d = win;
                  lock_cnt_d   = CNT_W'(1);
               end
            end
         end
         ACCESS: begin
            // Peripheral has driven ext_data_r on the mid-cycle negedge; capture for reads and writes.
            if (owner_q) begin
               m1_data_r_d = ext_data_r;
               m1_ack_d    = 1'b1;
            end else begin
               m0_data_r_d = ext_data_r;
               m0_ack_d    = 1'b1;
            end
            ext_op_d     = 1'b0;
            ext_rw_d     = 1'b0;
            ext_data_w_d = '0;
            state_d      = ACK;
         end
         ACK: begin
            m0_ack_d = 1'b0;
            m1_ack_d = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q      <= IDLE;
         ext_op_q     <= 1'b0;
         ext_rw_q     <= 1'b0;
         ext_addr_q   <= '0;
         ext_data_w_q <= '0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_data_r_q  <= '0;
         m1_data_r_q  <= '0;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         lock_valid_q <= 1'b0;
         lock_owner_q <= 1'b0;
         lock_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         ext_op_q     <= ext_op_d;
         ext_rw_q     <= ext_rw_d;
         ext_addr_q   <= ext_addr_d;
         ext_data_w_q <= ext_data_w_d;
         m0_ack_q     <= m0_ack_d;
         m1_ack_q     <= m1_ack_d;
         m0_data_r_q  <= m0_data_r_d;
         m1_data_r_q  <= m1_data_r_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   assign ext_op     = ext_op_q;
   assign ext_rw     = ext_rw_q;
   assign ext_addr   = ext_addr_q;
   assign ext_data_w = ext_data_w_q;
   assign m0_ack     = m0_ack_q;
   assign m1_ack     = m1_ack_q;
   assign m0_data_r  = m0_data_r_q;
   assign m1_data_r  = m1_data_r_q;
   assign owner      = owner_q;
   assign busy       = (state_q == ACCESS) || (state_q == ACK);

endmodule
